i2s_serializer: RTL
===================

# i2s_serializer

Output stage directly downstream of the flanger: takes one stereo sample pair per frame (the flanger's left/right outputs) through a one-entry valid/ready holding register and serializes it as a standard Philips I2S stream (BCLK, LRCLK, SDATA) toward the codec DAC. BCLK is derived from the system clock by an internal divider, so the block runs entirely in one clock domain. Missing samples are reported as underruns instead of corrupting the frame.

## Interface
- DATA_WIDTH, 16, sample width in bits (two's complement); must satisfy DATA_WIDTH < SLOT_WIDTH
- SLOT_WIDTH, 32, BCLK periods per channel slot
- BCLK_DIV, 2, clk cycles per BCLK half-period (≥1)

- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- audio_left_in  input  DATA_WIDTH  signed left sample
- audio_right_in  input  DATA_WIDTH  signed right sample
- sample_valid  input  1  left/right inputs hold a new pair
- sample_ready  output  1  holding register empty; pair accepted when sample_valid & sample_ready
- underrun_clr  input  1  clears underrun flag
- bclk  output  1  I2S bit clock
- lrclk  output  1  I2S word select (0 = left, 1 = right)
- sdata  output  1  I2S serial data, MSB first
- frame_start  output  1  one-clk pulse when a new frame's samples are loaded
- underrun  output  1  sticky: a frame started with the holding register empty

## Operation
- Reset values: bclk 0, lrclk 1, sdata 0, frame_start 0, underrun 0, sample_ready 1; div_cnt 0, bit_cnt 2*SLOT_WIDTH-1, holding empty, active left/right registers 0.
- Divider: div_cnt counts 0..BCLK_DIV-1; when div_cnt = BCLK_DIV-1, bclk toggles and div_cnt wraps to 0.
- Fall event: the cycle in which bclk is toggled from 1 to 0. All serial state changes only on fall events.
- On each fall event, bit_cnt increments modulo 2*SLOT_WIDTH. Slot position p = bit_cnt mod SLOT_WIDTH. Channel = bit_cnt ≥ SLOT_WIDTH (right) else left.
- lrclk = channel of the new bit_cnt. sdata = active_ch[DATA_WIDTH-p] for p in 1..DATA_WIDTH, else 0. MSB therefore appears one BCLK after the lrclk edge (I2S delay), and the remaining slot bits are zero padded.
- Load: on the fall event where bit_cnt wraps to 0:
  - If holding is full, copy left/right into the active registers and empty the holding register.
  - If holding is empty, keep the previous active values (the last pair repeats) and set underrun.
  - frame_start pulses in either case.
- Accept: when sample_valid & sample_ready, capture both inputs into holding and mark it full. sample_ready is registered and equals not-full.
- Accept and load in the same cycle: the load sees the pre-accept state. Holding was empty, so the load counts as an underrun, and the accepted pair remains in holding for the next frame.
- underrun stays set until underrun_clr is asserted or reset. If underrun_clr and a new underrun occur in the same cycle, the set wins.
- sample_valid while sample_ready = 0: ignored, with no overwrite of the holding register.
- Asynchronous reset mid-frame: all outputs return to their reset values immediately, and the held pair is discarded.

## Timing
- bclk period = 2*BCLK_DIV clk. Frame = 2*SLOT_WIDTH BCLK = 4*SLOT_WIDTH*BCLK_DIV clk (256 clk at defaults).
- After reset release, the first fall event occurs at clk edge 2*BCLK_DIV. That event is the first frame load: lrclk → 0, sdata stays 0 (p = 0).
- bclk, lrclk and sdata are all registered and change on the same clk edge (the BCLK falling edge). The receiver samples on the BCLK rising edge, BCLK_DIV clk later.
- Latency from accept to MSB on sdata: up to one frame plus one BCLK. A pair accepted before a load event produces its MSB exactly one BCLK (2*BCLK_DIV clk) after that frame_start.
- sample_ready deasserts on the clk edge after an accept and reasserts on the clk edge after the load.

## Test plan
- Reset then idle with no sample_valid: first frame_start at clk 4; underrun = 1 after it; sdata stays 0 for the full frame; lrclk is 0 for 32 BCLK, then 1 for 32.
- Accept L=0x8001, R=0x7FFE before the first load: left slot bits p1..p16 = 1000000000000001, right slot bits = 0111111111111110, positions 0 and 17..31 are 0, underrun stays 0.
- Stream of one pair per frame (L=i, R=-i for i=1..8): the bench deserializer recovers each pair in order with exactly one frame of latency and no underrun.
- Skip one pair in the stream: frame k repeats pair k-1 and underrun sets. Pulsing underrun_clr then clears it, and subsequent frames are correct.
- Assert sample_valid exactly on the load cycle while holding is empty: underrun sets and the pair plays in the next frame. A second sample_valid while full is ignored and holding is not overwritten.
- Assert reset_n low mid-right-slot at BCLK_DIV=3: outputs go to reset values asynchronously. After release, the first fall event is at clk 6 and the bclk period is 6 clk.

Source files
------------

// File: rtl/i2s_serializer_if.sv
// Sample handshake bundle between the flanger output and the I2S serializer.
//
// Valid/ready semantics: the source holds audio_left_in/audio_right_in stable
// while sample_valid is high. A pair transfers on a rising clk edge where
// sample_valid & sample_ready are both 1. sample_ready does not depend
// combinationally on sample_valid.
//
// Signals:
//   audio_left_in   DATA_WIDTH  signed left sample   (source -> serializer)
//   audio_right_in  DATA_WIDTH  signed right sample  (source -> serializer)
//   sample_valid    1           pair present         (source -> serializer)
//   sample_ready    1           holding reg empty    (serializer -> source)
interface i2s_serializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] audio_left_in;
  logic [DATA_WIDTH-1:0] audio_right_in;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output audio_left_in,
    output audio_right_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  audio_left_in,
    input  audio_right_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_serializer.sv
// Philips I2S output stage. Accepts one stereo pair per frame into a
// one-entry holding register and shifts it out MSB first, one BCLK after
// each LRCLK edge, with the rest of each slot zero padded. BCLK is divided
// down from clk so everything lives in the clk domain.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   smp          sample handshake (slave side of i2s_serializer_if)
//   underrun_clr clears the sticky underrun flag
//   bclk         I2S bit clock (2*BCLK_DIV clk period)
//   lrclk        word select, 0 = left, 1 = right
//   sdata        serial data, changes with bclk falling
//   frame_start  one-clk pulse on every frame load
//   underrun     sticky, a frame started with the holding register empty
module i2s_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  i2s_serializer_if.slave  smp,
  input  logic             underrun_clr,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             frame_start,
  output logic             underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] hold_right;
  logic [DATA_WIDTH-1:0] act_left;
  logic [DATA_WIDTH-1:0] act_right;

  logic                  div_wrap;
  logic                  fall;
  logic                  load;
  logic                  accept;
  logic [BIT_W-1:0]      bit_nxt;
  logic [BIT_W-1:0]      pos;
  logic                  right_nxt;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sdata_nxt;

  always_comb begin
    div_wrap  = (div_cnt == DIV_W'(BCLK_DIV - 1));
    // Serial state only moves when bclk is about to go 1 -> 0.
    fall      = div_wrap & bclk;
    bit_nxt   = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
    right_nxt = (bit_nxt >= BIT_W'(SLOT_WIDTH));
    pos       = right_nxt ? bit_nxt - BIT_W'(SLOT_WIDTH) : bit_nxt;
    word      = right_nxt ? act_right : act_left;
    // Slot position p carries word[DATA_WIDTH-p]; shifting left by p-1
    // brings that bit to the MSB. Position 0 is the one-BCLK I2S delay.
    shifted   = word << (pos - BIT_W'(1));
    sdata_nxt = ((pos != '0) && (pos <= BIT_W'(DATA_WIDTH))) ?
                shifted[DATA_WIDTH-1] : 1'b0;
    load      = fall & (bit_nxt == '0);
    accept    = smp.sample_valid & ~hold_full;
  end

  // hold_full is a flop, so ready is registered and independent of valid.
  assign smp.sample_ready = ~hold_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Reset bit_cnt sits on the last bit so the first fall wraps to 0 and
  // performs the first frame load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= BIT_W'(FRAME_BITS - 1);
      lrclk       <= 1'b1;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= right_nxt;
        sdata   <= sdata_nxt;
      end
    end
  end

  // A load and an accept in the same cycle cannot both touch hold_full:
  // accept needs it empty, and an empty load only flags underrun, so the
  // accepted pair stays in holding for the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full  <= 1'b0;
      hold_left  <= '0;
      hold_right <= '0;
      act_left   <= '0;
      act_right  <= '0;
    end else begin
      if (load && hold_full) begin
        act_left  <= hold_left;
        act_right <= hold_right;
        hold_full <= 1'b0;
      end
      if (accept) begin
        hold_left  <= smp.audio_left_in;
        hold_right <= smp.audio_right_in;
        hold_full  <= 1'b1;
      end
    end
  end

  // A new underrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
    end else if (load && !hold_full) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule
